boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_pkg.sv | 17 +
 rtl/boot_loader.sv | 152 +++++++++++++++
 tb/tb_boot_loader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/boot_pkg.sv
// Shared definitions for the serial boot loader: FSM state encoding and frame start byte.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_WRITE,
        ST_CSUM,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam logic [7:0] DEFAULT_MAGIC = 8'hA5;

endpackage

// File: rtl/boot_loader.sv
// Byte-stream boot loader: receives a framed image, writes it word by word into
// instruction memory, verifies an XOR checksum and then releases the core from reset.
module boot_loader
    import boot_pkg::*;
#(
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [7:0]  MAGIC      = DEFAULT_MAGIC
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    output logic        o_imem_we,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_wdata,
    output logic        o_core_resetn,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    localparam logic [31:0] WORD_LIMIT = 32'(IMEM_WORDS);

    state_t      state, state_n;
    logic        run_en;
    logic [15:0] len, len_n;
    logic [15:0] idx, idx_n;
    logic [1:0]  lane, lane_n;
    logic [7:0]  csum, csum_n;
    logic [31:0] word, word_n;
    logic [31:0] addr, addr_n;
    logic        take;
    logic [15:0] len_full;

    // The FSM is held for one edge after reset release so it leaves reset synchronously.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state <= ST_IDLE;
            len   <= '0;
            idx   <= '0;
            lane  <= '0;
            csum  <= '0;
            word  <= '0;
            addr  <= BASE_ADDR;
        end else begin
            state <= state_n;
            len   <= len_n;
            idx   <= idx_n;
            lane  <= lane_n;
            csum  <= csum_n;
            word  <= word_n;
            addr  <= addr_n;
        end
    end

    assign take     = i_rx_valid && o_rx_ready;
    assign len_full = {i_rx_data, len[7:0]};

    always_comb begin
        state_n = state;
        len_n   = len;
        idx_n   = idx;
        lane_n  = lane;
        csum_n  = csum;
        word_n  = word;
        addr_n  = addr;
        if (run_en) begin
            case (state)
                ST_IDLE, ST_ERROR: begin
                    if (take && i_rx_data == MAGIC) begin
                        state_n = ST_LEN_LO;
                        csum_n  = '0;
                        idx_n   = '0;
                        lane_n  = '0;
                    end
                end
                ST_LEN_LO: begin
                    if (take) begin
                        len_n[7:0] = i_rx_data;
                        csum_n     = csum ^ i_rx_data;
                        state_n    = ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (take) begin
                        len_n[15:8] = i_rx_data;
                        csum_n      = csum ^ i_rx_data;
                        idx_n       = '0;
                        lane_n      = '0;
                        addr_n      = BASE_ADDR;
                        if ({16'd0, len_full} > WORD_LIMIT) begin
                            state_n = ST_ERROR;
                        end else if (len_full == 16'd0) begin
                            state_n = ST_CSUM;
                        end else begin
                            state_n = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (take) begin
                        word_n[{lane, 3'b000} +: 8] = i_rx_data;
                        csum_n = csum ^ i_rx_data;
                        lane_n = lane + 2'd1;
                        if (lane == 2'd3) begin
                            state_n = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    // The length check before DATA guarantees idx+1 reaches len without wrapping.
                    idx_n  = idx + 16'd1;
                    addr_n = addr + 32'd4;
                    lane_n = '0;
                    state_n = ((idx + 16'd1) == len) ? ST_CSUM : ST_DATA;
                end
                ST_CSUM: begin
                    if (take) begin
                        state_n = (i_rx_data == csum) ? ST_RUN : ST_ERROR;
                    end
                end
                ST_RUN: begin
                    state_n = ST_RUN;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    assign o_rx_ready    = (state != ST_WRITE);
    assign o_imem_we     = (state == ST_WRITE);
    assign o_imem_addr   = addr;
    assign o_imem_wdata  = word;
    assign o_core_resetn = (state == ST_RUN);
    assign o_done        = (state == ST_RUN);
    assign o_error       = (state == ST_ERROR);
    assign o_busy        = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA) ||
                           (state == ST_WRITE)  || (state == ST_CSUM);

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: frames with hand-computed checksums, write capture and reset cases.
module tb_boot_loader;

    typedef logic [7:0] bytes_t[$];

    logic        i_clk;
    logic        i_resetn;
    logic        i_rx_valid;
    logic [7:0]  i_rx_data;
    logic        o_rx_ready;
    logic        o_imem_we;
    logic [31:0] o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_core_resetn;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int n_cmp;
    int n_bad;
    int rdy_viol;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    boot_loader #(
        .IMEM_WORDS(256),
        .BASE_ADDR (32'h0000_0000),
        .MAGIC     (8'hA5)
    ) dut (
        .i_clk        (i_clk),
        .i_resetn     (i_resetn),
        .i_rx_valid   (i_rx_valid),
        .i_rx_data    (i_rx_data),
        .o_rx_ready   (o_rx_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_core_resetn(o_core_resetn),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_imem_we === 1'b1) begin
            wr_addr.push_back(o_imem_addr);
            wr_data.push_back(o_imem_wdata);
            if (o_rx_ready !== 1'b0) rdy_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        i_rx_valid = 1'b0;
        i_resetn   = 1'b0;
        @(negedge i_clk);
        wr_addr.delete();
        wr_data.delete();
        rdy_viol = 0;
        i_resetn = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        logic got;
        got = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        for (int k = 0; k < 8; k++) begin
            rdy = o_rx_ready;
            @(posedge i_clk);
            @(negedge i_clk);
            if (rdy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("rx_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic send_seq(input bytes_t bs);
        foreach (bs[i]) send_byte(bs[i]);
        i_rx_valid = 1'b0;
    endtask

    initial begin
        bytes_t good, bad;
        n_cmp = 0;
        n_bad = 0;
        rdy_viol = 0;
        i_resetn   = 1'b0;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        // XOR over 02 00 13 00 00 00 93 00 10 00 (length bytes included) = 0x92
        good = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        bad  = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h81};

        // Reset state
        #12;
        check("rst_core_resetn", {31'd0, o_core_resetn}, 32'd0);
        check("rst_we",          {31'd0, o_imem_we},     32'd0);
        check("rst_busy",        {31'd0, o_busy},        32'd0);
        check("rst_done",        {31'd0, o_done},        32'd0);
        check("rst_error",       {31'd0, o_error},       32'd0);
        check("rst_ready",       {31'd0, o_rx_ready},    32'd1);
        check("rst_addr",        o_imem_addr,            32'h0000_0000);
        check("rst_wdata",       o_imem_wdata,           32'h0000_0000);

        // Good two-word frame, valid held high throughout
        apply_reset();
        send_byte(8'hA5);
        check("busy_after_magic", {31'd0, o_busy}, 32'd1);
        for (int i = 1; i < 12; i++) send_byte(good[i]);
        i_rx_valid = 1'b0;
        @(negedge i_clk);
        check("a_nwrites", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check("a_addr0", wr_addr[0], 32'h0000_0000);
            check("a_data0", wr_data[0], 32'h0000_0013);
            check("a_addr1", wr_addr[1], 32'h0000_0004);
            check("a_data1", wr_data[1], 32'h0010_0093);
        end
        check("a_ready_in_write", rdy_viol, 32'd0);
        check("a_done",       {31'd0, o_done},        32'd1);
        check("a_core_resetn",{31'd0, o_core_resetn}, 32'd1);
        check("a_busy",       {31'd0, o_busy},        32'd0);
        send_seq('{8'hA5, 8'h55});
        check("a_run_sticky", {31'd0, o_done},        32'd1);
        check("a_run_nowr",   wr_addr.size(),         32'd2);

        // Bad checksum, then a correct frame
        apply_reset();
        send_seq(bad);
        @(negedge i_clk);
        check("b_nwrites",    wr_addr.size(),         32'd2);
        check("b_error",      {31'd0, o_error},       32'd1);
        check("b_core_resetn",{31'd0, o_core_resetn}, 32'd0);
        check("b_done",       {31'd0, o_done},        32'd0);
        send_seq(good);
        @(negedge i_clk);
        check("b_recover_done",  {31'd0, o_done},  32'd1);
        check("b_recover_error", {31'd0, o_error}, 32'd0);
        check("b_recover_nwr",   wr_addr.size(),   32'd4);

        // Oversized length
        apply_reset();
        send_seq('{8'hA5, 8'h01, 8'h01});
        repeat (3) @(negedge i_clk);
        check("c_error",   {31'd0, o_error}, 32'd1);
        check("c_nwrites", wr_addr.size(),   32'd0);

        // Leading junk, then empty image
        apply_reset();
        send_seq('{8'h11, 8'h22});
        check("d_junk_busy", {31'd0, o_busy}, 32'd0);
        send_seq('{8'hA5, 8'h00, 8'h00, 8'h00});
        @(negedge i_clk);
        check("d_done",    {31'd0, o_done}, 32'd1);
        check("d_nwrites", wr_addr.size(),  32'd0);

        // Reset mid-frame after six data bytes
        apply_reset();
        send_seq('{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
        check("e_busy_pre", {31'd0, o_busy}, 32'd1);
        #2;
        i_resetn = 1'b0;
        #1;
        check("e_busy_now",   {31'd0, o_busy},        32'd0);
        check("e_we_now",     {31'd0, o_imem_we},     32'd0);
        check("e_core_now",   {31'd0, o_core_resetn}, 32'd0);
        check("e_addr_now",   o_imem_addr,            32'h0000_0000);
        repeat (4) @(negedge i_clk);
        check("e_nwrites",    wr_addr.size(),         32'd1);
        if (wr_data.size() >= 1) check("e_data0", wr_data[0], 32'h0403_0201);
        i_resetn = 1'b1;
        repeat (3) @(negedge i_clk);
        check("e_idle_after", {31'd0, o_busy},        32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
